token_classifier: RTL and testbench

TOKEN_CLASSIFIER -- requirements
Module: token_classifier

---
 rtl/token_pkg.sv | 53 +++++
 rtl/token_classifier_char_kind.sv | 31 +++
 rtl/token_classifier.sv | 168 ++++++++++++++++
 tb/tb_token_classifier.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// Shared encodings for the token classifier and its neighbouring stages:
// character kinds, token classes, FSM states and the class-decision helper.
package token_pkg;

    // Kind of a single input character.
    typedef enum logic [1:0] {
        KIND_DELIM  = 2'd0,
        KIND_LETTER = 2'd1,
        KIND_DIGIT  = 2'd2
    } kind_e;

    // Class reported with each emitted token record.
    typedef enum logic [1:0] {
        CLS_WORD     = 2'd0,
        CLS_ID_NUM   = 2'd1,
        CLS_ID_ALPHA = 2'd2,
        CLS_NUMBER   = 2'd3
    } class_e;

    // Tokenizer FSM states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_TOK = 1'b1
    } state_e;

    // ASCII range bounds used by the character decoder.
    localparam logic [7:0] ASCII_0       = 8'h30;
    localparam logic [7:0] ASCII_9       = 8'h39;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

    // Class priority: a leading digit makes a number, otherwise a trailing
    // digit makes a numbered identifier, otherwise any embedded digit makes
    // an alphanumeric identifier, and a token with no digits is a word.
    function automatic class_e classify(input kind_e first_kind,
                                        input kind_e last_kind,
                                        input logic  saw_digit);
        class_e cls;
        if (first_kind == KIND_DIGIT) begin
            cls = CLS_NUMBER;
        end else if (last_kind == KIND_DIGIT) begin
            cls = CLS_ID_NUM;
        end else if (saw_digit) begin
            cls = CLS_ID_ALPHA;
        end else begin
            cls = CLS_WORD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/token_classifier_char_kind.sv
// Combinational ASCII decoder: maps one 8-bit code to LETTER, DIGIT or DELIM.
// Codes outside the letter and digit ranges (including NUL and the upper
// half of the code space) are delimiters.
module char_kind
    import token_pkg::*;
(
    input  logic [7:0] code_i,
    output kind_e      kind_o
);

    logic is_upper;
    logic is_lower;
    logic is_digit;

    assign is_upper = (code_i >= ASCII_UPPER_A) && (code_i <= ASCII_UPPER_Z);
    assign is_lower = (code_i >= ASCII_LOWER_A) && (code_i <= ASCII_LOWER_Z);
    assign is_digit = (code_i >= ASCII_0)       && (code_i <= ASCII_9);

    // Decode the character kind; delimiter is the fallback for every other code.
    always_comb begin
        // NOTE: assigning a default first means every path drives kind_o, so
        // no latch is inferred even if a branch is later removed.
        kind_o = KIND_DELIM;
        if (is_upper || is_lower) begin
            kind_o = KIND_LETTER;
        end else if (is_digit) begin
            kind_o = KIND_DIGIT;
        end
    end

endmodule

// File: rtl/token_classifier.sv
// Token classifier: splits a character stream into delimiter-separated
// tokens and emits one record (class, saturating length, overflow flag) per
// terminated token through a one-deep output register with valid/ready
// handshake. Also counts emitted ID_NUM records.
module token_classifier
    import token_pkg::*;
#(
    parameter int LEN_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       tok_class,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] id_num_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    // Current character kind from the shared decoder.
    kind_e cur_kind;

    char_kind u_char_kind (
        .code_i (char),
        .kind_o (cur_kind)
    );

    // Tokenizer state and per-token accumulators.
    state_e           state_q,      state_d;
    logic [LEN_W-1:0] len_q,        len_d;
    logic             ovf_q,        ovf_d;
    kind_e            first_kind_q, first_kind_d;
    kind_e            last_kind_q,  last_kind_d;
    logic             saw_digit_q,  saw_digit_d;

    // Output record register and ID_NUM counter.
    logic             out_valid_q,  out_valid_d;
    class_e           out_class_q,  out_class_d;
    logic [LEN_W-1:0] out_len_q,    out_len_d;
    logic             out_ovf_q,    out_ovf_d;
    logic [CNT_W-1:0] id_cnt_q,     id_cnt_d;

    logic   accept;
    logic   load_rec;
    class_e rec_class;

    // A free output slot, or one being drained this edge, lets a char in.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // A delimiter accepted inside a token closes it and loads a record.
    assign load_rec  = accept && (state_q == ST_IN_TOK) && (cur_kind == KIND_DELIM);
    assign rec_class = classify(first_kind_q, last_kind_q, saw_digit_q);

    // Next-state logic for the tokenizer FSM and its accumulators.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        first_kind_d = first_kind_q;
        last_kind_d  = last_kind_q;
        saw_digit_d  = saw_digit_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && (cur_kind != KIND_DELIM)) begin
                    state_d      = ST_IN_TOK;
                    len_d        = LEN_W'(1);
                    ovf_d        = 1'b0;
                    first_kind_d = cur_kind;
                    last_kind_d  = cur_kind;
                    saw_digit_d  = (cur_kind == KIND_DIGIT);
                end
            end
            ST_IN_TOK: begin
                if (accept) begin
                    if (cur_kind == KIND_DELIM) begin
                        // Record is captured from the _q values this edge;
                        // the accumulators start clean for the next token.
                        state_d      = ST_IDLE;
                        len_d        = '0;
                        ovf_d        = 1'b0;
                        first_kind_d = KIND_DELIM;
                        last_kind_d  = KIND_DELIM;
                        saw_digit_d  = 1'b0;
                    end else begin
                        if (len_q == LEN_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            len_d = len_q + LEN_W'(1);
                        end
                        last_kind_d = cur_kind;
                        saw_digit_d = saw_digit_q | (cur_kind == KIND_DIGIT);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next-state logic for the output record register and ID_NUM counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_class_d = out_class_q;
        out_len_d   = out_len_q;
        out_ovf_d   = out_ovf_q;
        id_cnt_d    = id_cnt_q;

        if (load_rec) begin
            // Covers drain-and-reload on the same edge: valid stays high.
            out_valid_d = 1'b1;
            out_class_d = rec_class;
            out_len_d   = len_q;
            out_ovf_d   = ovf_q;
            if (rec_class == CLS_ID_NUM) begin
                id_cnt_d = id_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Single state register for the FSM, accumulators and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            first_kind_q <= KIND_DELIM;
            last_kind_q  <= KIND_DELIM;
            saw_digit_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_class_q  <= CLS_WORD;
            out_len_q    <= '0;
            out_ovf_q    <= 1'b0;
            id_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would chain updates within one edge.
            state_q      <= state_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            first_kind_q <= first_kind_d;
            last_kind_q  <= last_kind_d;
            saw_digit_q  <= saw_digit_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_len_q    <= out_len_d;
            out_ovf_q    <= out_ovf_d;
            id_cnt_q     <= id_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign tok_class    = out_class_q;
    assign tok_len      = out_len_q;
    assign tok_ovf      = out_ovf_q;
    assign id_num_count = id_cnt_q;

endmodule

// File: tb/tb_token_classifier.sv
// Directed bench for token_classifier: expected records are queued as each
// stream is driven and compared by a monitor when the DUT hands a record off.
module tb_token_classifier;

    localparam int LEN_W = 6;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [7:0]       ch;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       tok_class;
    logic [LEN_W-1:0] tok_len;
    logic             tok_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] id_num_count;

    typedef struct packed {
        logic [1:0]       cls;
        logic [LEN_W-1:0] len;
        logic             ovf;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    token_classifier #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .char         (ch),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .tok_class    (tok_class),
        .tok_len      (tok_len),
        .tok_ovf      (tok_ovf),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .id_num_count (id_num_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input logic [1:0] cls, input logic [LEN_W-1:0] len, input logic ovf);
        rec_t r;
        r.cls = cls;
        r.len = len;
        r.ovf = ovf;
        exp_q.push_back(r);
    endtask

    // Scoreboard: a record is handed off when valid and ready meet at an edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check("record_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                rec_t r;
                r = exp_q.pop_front();
                check("rec_class", tok_class, r.cls);
                check("rec_len",   tok_len,   r.len);
                check("rec_ovf",   tok_ovf,   r.ovf);
            end
        end
    end

    // Inputs change 2 time units after a rising edge; acceptance is judged
    // from in_ready sampled at the falling edge before the next rising edge.
    task automatic send_char(input logic [7:0] c);
        int waits;
        waits = 0;
        ch       = c;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                check("accept_budget", waits, 0);
                break;
            end
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
        end
    endtask

    task automatic send_run(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            send_char(c);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid,    0);
        check("rst_tok_class", tok_class,    0);
        check("rst_tok_len",   tok_len,      0);
        check("rst_tok_ovf",   tok_ovf,      0);
        check("rst_id_count",  id_num_count, 0);
        check("rst_in_ready",  in_ready,     1);
        reset = 1'b0;
        idle_cycles(1);
    endtask

    task automatic drain_and_check(input string tag);
        idle_cycles(3);
        check({tag, "_all_records_seen"}, exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        ch        = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3;
        apply_reset();

        // Delimiters only: no record ever appears.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = (i < 2) ? 8'h20 : 8'h2C;
            send_char(d);
            check("delim_only_valid", out_valid, 0);
        end
        send_char(8'h00);
        send_char(8'h80);
        check("delim_high_valid", out_valid, 0);
        drain_and_check("delim_only");
        check("delim_only_count", id_num_count, 0);

        // "x9y,7a;" -> ID_ALPHA len 3, then NUMBER len 2.
        apply_reset();
        push_rec(2'd2, 6'd3, 1'b0);
        push_rec(2'd3, 6'd2, 1'b0);
        send_str("x9y,7a;");
        drain_and_check("mixed");
        check("mixed_count", id_num_count, 0);

        // 70 letters saturate the length and raise overflow.
        apply_reset();
        push_rec(2'd0, 6'd63, 1'b1);
        send_run(8'h7A, 70);
        send_char(8'h20);
        drain_and_check("long70");

        // Saturation boundary: exactly 63 fits, 64 overflows.
        push_rec(2'd0, 6'd63, 1'b0);
        send_run(8'h6D, 63);
        send_char(8'h20);
        push_rec(2'd0, 6'd63, 1'b1);
        send_run(8'h6D, 64);
        send_char(8'h20);
        drain_and_check("len_edge");
        check("len_edge_count", id_num_count, 0);

        // Back-pressure: "cat" held while out_ready is low, then "d1".
        apply_reset();
        out_ready = 1'b0;
        push_rec(2'd0, 6'd3, 1'b0);
        push_rec(2'd1, 6'd2, 1'b0);
        send_str("cat ");
        ch       = 8'h64;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hold_in_ready",  in_ready,  0);
            check("hold_out_valid", out_valid, 1);
            check("hold_class",     tok_class, 0);
            check("hold_len",       tok_len,   3);
            check("hold_ovf",       tok_ovf,   0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        send_char(8'h64);
        send_str("1 ");
        drain_and_check("backpressure");
        check("backpressure_count", id_num_count, 1);

        // "ab12 " -> ID_NUM len 4 and the counter steps to 1.
        apply_reset();
        push_rec(2'd1, 6'd4, 1'b0);
        send_str("ab12 ");
        drain_and_check("idnum");
        check("idnum_count", id_num_count, 1);

        // Mid-token asynchronous reset discards "ab1"; "q " follows cleanly.
        send_str("ab1");
        #1;
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid,    0);
        check("async_tok_class", tok_class,    0);
        check("async_tok_len",   tok_len,      0);
        check("async_tok_ovf",   tok_ovf,      0);
        check("async_id_count",  id_num_count, 0);
        check("async_in_ready",  in_ready,     1);
        reset = 1'b0;
        push_rec(2'd0, 6'd1, 1'b0);
        send_str("q ");
        drain_and_check("after_reset");
        check("after_reset_count", id_num_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
